rr_port_arbiter: RTL and testbench

RR_PORT_ARBITER -- requirements
Module: rr_port_arbiter

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 49 ++++
 rtl/rr_port_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin port arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int COUNT_W       = 8;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrapped priority pick: first set req bit at or after ptr, modulo NREQ.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick_onehot,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_valid
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   hit;
  logic [2*NREQ-1:0] hit_dbl;

  // Rotate so that bit 0 of rot is requester ptr; bit k is (ptr+k) mod NREQ.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: NREQ];

  // Keep only the lowest set bit of the rotated vector.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_hit
      if (gi == 0) begin : g_first
        assign hit[gi] = rot[gi];
      end else begin : g_rest
        assign hit[gi] = rot[gi] & ~(|rot[gi-1:0]);
      end
    end
  endgenerate

  // Rotate the winner back: rotated bit k lands on requester (k+ptr) mod NREQ.
  assign hit_dbl     = {hit, hit} << ptr;
  assign pick_onehot = hit_dbl[2*NREQ-1:NREQ];
  assign pick_valid  = |req;

  // Binary-encode the one-hot winner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) pick_idx = pick_idx | IW'(i);
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst tenure on a
// shared port; tenure ends on last beat, burst limit, or request withdrawal.
module rr_port_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW       = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  input  logic            port_ready,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id,
  output logic            port_valid,
  output logic            busy
);

  localparam logic [COUNT_W:0] BURST_LIM = (COUNT_W+1)'(MAX_BURST);

  arb_state_t       state_reg, state_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [IW-1:0]    grant_id_reg, grant_id_next;
  logic             busy_reg, busy_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             owner_last;
  logic             beat;
  logic [COUNT_W:0] count_plus;
  logic             burst_done;
  logic [IW-1:0]    ptr_after_owner;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req         (req),
    .ptr         (ptr_reg),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  // grant_id is zero while idle, so it doubles as the owner index in GRANT.
  assign owner_req       = req[grant_id_reg];
  assign owner_last      = last[grant_id_reg];
  assign port_valid      = busy_reg & owner_req & ~stall;
  assign beat            = port_valid & port_ready;
  assign count_plus      = {1'b0, count_reg} + (COUNT_W+1)'(1);
  assign burst_done      = (count_plus == BURST_LIM);
  assign ptr_after_owner = (grant_id_reg == IW'(NREQ-1)) ? '0 : grant_id_reg + IW'(1);

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;

  // Next-state and next-output decode; stall freezes everything.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    busy_next     = busy_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        if (!stall && pick_valid) begin
          state_next    = GRANT;
          grant_next    = pick_onehot;
          grant_id_next = pick_idx;
          busy_next     = 1'b1;
          count_next    = '0;
        end
      end
      GRANT: begin
        if (!stall) begin
          if (beat) count_next = count_plus[COUNT_W-1:0];
          // Any combination of release causes collapses into one release.
          if ((beat && (owner_last || burst_done)) || !owner_req) begin
            state_next    = IDLE;
            grant_next    = '0;
            grant_id_next = '0;
            busy_next     = 1'b0;
            ptr_next      = ptr_after_owner;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        grant_next    = '0;
        grant_id_next = '0;
        busy_next     = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
      ptr_reg      <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Scoreboard bench for rr_port_arbiter: each expected tenure (owner, beat
// count, idle gap before it) is queued with the stimulus and checked as the
// DUT starts and ends tenures.
module tb_rr_port_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 8;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       stall      = 1'b0;
  logic       port_ready = 1'b0;
  logic [3:0] req        = '0;
  logic [3:0] last       = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       port_valid;
  logic       busy;

  always #5 clk = ~clk;

  rr_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req        (req),
    .last       (last),
    .port_ready (port_ready),
    .grant      (grant),
    .grant_id   (grant_id),
    .port_valid (port_valid),
    .busy       (busy)
  );

  typedef struct {
    int id;
    int beats;
    int gap;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   passed = 0;
  int   total  = 0;
  int   tenure_beats  = 0;
  int   idle_cnt      = 0;
  int   tenures_done  = 0;
  int   tenure_starts = 0;
  logic prev_busy     = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic expect_tenure(input int id, input int beats, input int gap);
    exp_t e;
    e.id = id; e.beats = beats; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Called once per cycle at the falling edge; had_beat is the handshake
  // that was present at the rising edge just passed.
  task automatic monitor(input logic had_beat);
    if (had_beat) tenure_beats++;
    if (busy && !prev_busy) begin
      tenure_starts++;
      if (sb_q.size() == 0) begin
        check("unexpected_grant", int'(grant_id), -1);
        cur = '{-1, -1, -1};
      end else begin
        cur = sb_q.pop_front();
        check("grant_id", int'(grant_id), cur.id);
        check("grant_onehot", int'(grant), 1 << cur.id);
        if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
        $display("tenure start: owner %0d grant %b", grant_id, grant);
      end
      tenure_beats = 0;
      idle_cnt     = 0;
    end else if (!busy && prev_busy) begin
      check("tenure_beats", tenure_beats, cur.beats);
      $display("tenure end: owner %0d beats %0d", cur.id, tenure_beats);
      tenures_done++;
    end
    if (!busy) idle_cnt++;
    prev_busy = busy;
  endtask

  task automatic tick();
    logic b;
    #1;
    b = port_valid && port_ready;
    @(negedge clk);
    monitor(b);
  endtask

  // which: 0 = tenure starts, 1 = tenures ended, 2 = beats in current tenure
  task automatic wait_for(input int which, input int target, input string tag);
    int k = 0;
    int v;
    v = (which == 0) ? tenure_starts : (which == 1) ? tenures_done : tenure_beats;
    while (v < target && k < 200) begin
      tick();
      k++;
      v = (which == 0) ? tenure_starts : (which == 1) ? tenures_done : tenure_beats;
    end
    if (v < target) check({tag, "_timeout"}, v, target);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; req = '0; last = '0; stall = 1'b0; port_ready = 1'b0;
    #1;
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_grant_id"}, int'(grant_id), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_port_valid"}, int'(port_valid), 0);
    tick();
    tick();
    reset = 1'b0;
    tenures_done  = 0;
    tenure_starts = 0;
  endtask

  task automatic drain(input string tag);
    req = '0;
    tick(); tick(); tick();
    check({tag, "_sb_drained"}, sb_q.size(), 0);
  endtask

  initial begin
    // Rotation with single-beat tenures and one idle cycle between them.
    do_reset("rst0");
    req = 4'b1111; last = 4'b1111; port_ready = 1'b1;
    expect_tenure(0, 1, -1);
    expect_tenure(1, 1, 1);
    expect_tenure(2, 1, 1);
    expect_tenure(3, 1, 1);
    expect_tenure(0, 1, 1);
    wait_for(1, 5, "rotate");
    drain("rotate");

    // Burst limit: eight beats, release, regrant to the same lone requester.
    do_reset("rst1");
    req = 4'b0100; last = 4'b0000; port_ready = 1'b1;
    expect_tenure(2, MAX_BURST, -1);
    expect_tenure(2, MAX_BURST, 1);
    wait_for(1, 2, "burst");
    drain("burst");

    // Stall mid-tenure freezes grant and beat count.
    do_reset("rst2");
    req = 4'b0010; last = 4'b0000; port_ready = 1'b1;
    expect_tenure(1, MAX_BURST, -1);
    wait_for(0, 1, "stall_start");
    wait_for(2, 2, "stall_beats");
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_port_valid", int'(port_valid), 0);
      check("stall_grant", int'(grant), 4'b0010);
      check("stall_beats_held", tenure_beats, 2);
    end
    stall = 1'b0;
    wait_for(1, 1, "stall_end");
    drain("stall");

    // Stall in idle blocks arbitration; owner 3 release wraps ptr to 0.
    do_reset("rst3");
    req = 4'b1000; last = 4'b1111; port_ready = 1'b1; stall = 1'b1;
    expect_tenure(3, 1, -1);
    expect_tenure(0, 1, 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("idle_stall_busy", int'(busy), 0);
    end
    stall = 1'b0;
    wait_for(0, 1, "wrap_start");
    req = 4'b1001;
    wait_for(1, 2, "wrap");
    drain("wrap");

    // Reset in the middle of a tenure, then a fresh grant one edge later.
    do_reset("rst4");
    req = 4'b0001; last = 4'b0000; port_ready = 1'b1;
    expect_tenure(0, 3, -1);
    wait_for(0, 1, "midrst_start");
    wait_for(2, 3, "midrst_beats");
    reset = 1'b1;
    #1;
    check("midrst_grant", int'(grant), 0);
    check("midrst_grant_id", int'(grant_id), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_port_valid", int'(port_valid), 0);
    req = 4'b0010; last = 4'b0010;
    tick();
    reset = 1'b0;
    expect_tenure(1, 1, -1);
    tick();
    check("grant_one_edge", int'(grant), 4'b0010);
    wait_for(1, 2, "midrst_end");
    drain("midrst");

    // Owner withdraws its request with no beats; ptr still advances.
    do_reset("rst5");
    req = 4'b0001; last = 4'b0000; port_ready = 1'b0;
    expect_tenure(0, 0, -1);
    expect_tenure(1, 1, 1);
    wait_for(0, 1, "drop_start");
    req = 4'b0010; last = 4'b0011; port_ready = 1'b1;
    tick();
    check("drop_release_busy", int'(busy), 0);
    req = 4'b0011;
    wait_for(1, 2, "drop");
    drain("drop");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
